// File: rtl/loader_pkg.sv
// Shared types and rules for the program loader: FSM states, default sync
// marker and the LEN validity check.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // A frame must carry at least one word and no more than the memory holds.
  function automatic logic len_ok(input logic [7:0] len, input int unsigned addr_w);
    logic [31:0] max_words;
    max_words = 32'd1 << addr_w;
    return (len != 8'd0) && ({24'd0, len} <= max_words);
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Little-endian byte-to-word packer: first byte lands in word[7:0].
module loader_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        shift_en,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (clear) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= {byte_in, word[31:8]};
      cnt  <= cnt + 2'd1;
    end
  end

  // High in the cycle the fourth byte is shifted in.
  assign word_done = shift_en && (cnt == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader for instruction memory: SYNC, LEN, 4*LEN data bytes.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              load_mem_en,
  output logic [ADDR_W-1:0] load_mem_addr,
  output logic [31:0]       load_mem_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] WCNT_ONE = (ADDR_W+1)'(1);

  state_t            state, state_nx;
  logic              acc, pk_shift, pk_clear, pk_done;
  logic [31:0]       pk_word;
  logic [ADDR_W:0]   wcnt, nwords;
  logic              last_word;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  assign s_ready   = (state == IDLE) || (state == LEN) || (state == DATA) || (state == CSUM);
  assign acc       = s_valid && s_ready;
  assign pk_shift  = acc && (state == DATA);
  assign pk_clear  = acc && (state == LEN);
  assign last_word = (wcnt + WCNT_ONE) == nwords;

  loader_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (s_data),
    .shift_en  (pk_shift),
    .clear     (pk_clear),
    .word      (pk_word),
    .word_done (pk_done)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        csum <= '0;
    else if (pk_clear) csum <= '0;
    else if (pk_shift) csum <= csum + s_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (acc && (s_data == SYNC_BYTE)) state_nx = LEN;
      LEN:   if (acc) state_nx = len_ok(s_data, ADDR_W) ? DATA : ERR;
      DATA:  if (pk_done) state_nx = WRITE;
`ifdef LOADER_CHECKSUM_EN
      WRITE: state_nx = last_word ? CSUM : DATA;
      CSUM:  if (acc) state_nx = (s_data == csum) ? DONE : ERR;
`else
      WRITE: state_nx = last_word ? DONE : DATA;
`endif
      DONE:  state_nx = IDLE;
      ERR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Word counter is one bit wider than the address so a full-memory frame
  // terminates on count == 2^ADDR_W instead of wrapping to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt   <= '0;
      nwords <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (pk_clear) begin
      wcnt   <= '0;
      nwords <= (ADDR_W+1)'(s_data);
    end else if (state == WRITE) begin
      wcnt   <= wcnt + WCNT_ONE;
      addr_q <= wcnt[ADDR_W-1:0];
      data_q <= pk_word;
    end
  end

  // Address/data follow the live write in WRITE and hold the last write otherwise.
  assign load_mem_en   = (state == WRITE);
  assign load_mem_addr = load_mem_en ? wcnt[ADDR_W-1:0] : addr_q;
  assign load_mem_data = load_mem_en ? pk_word : data_q;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign err           = (state == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a frame-level model.
// Build with LOADER_CHECKSUM_EN defined to exercise the checksum variant.
module tb_program_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          s_valid = 1'b0;
  logic          s_ready, load_mem_en, busy, done, err;
  logic [AW-1:0] load_mem_addr;
  logic [31:0]   load_mem_data;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .load_mem_en   (load_mem_en),
    .load_mem_addr (load_mem_addr),
    .load_mem_data (load_mem_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  // kind: 0 = write, 1 = done, 2 = err
  typedef struct { int kind; int addr; logic [31:0] data; } ev_t;
  typedef struct { string name; logic [31:0] got; logic [31:0] exp; } lit_t;

  ev_t         expq[$];
  lit_t        litq[$];
  logic [7:0]  stream[$];
  logic [31:0] mem[16];
  logic [31:0] words[16];
  logic [7:0]  fsum;
  int          ncmp = 0;
  int          nmis = 0;
  bit          prev_en = 1'b0, prev_term = 1'b0, exp_done_nx = 1'b0;

  function automatic void lit(string n, logic [31:0] g, logic [31:0] e);
    lit_t t;
    t.name = n; t.got = g; t.exp = e;
    litq.push_back(t);
  endfunction

  task automatic chk(string n, logic [31:0] g, logic [31:0] e);
    ncmp++;
    if (g !== e) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, g, e, $time);
    end
  endtask

  // Frame-level reference: walk the byte stream and list the writes and
  // terminations the loader must produce, in order.
  task automatic model_frames();
    int i;
    int n;
    logic [7:0]  sum;
    logic [31:0] w;
    ev_t e;
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] != 8'hA5) begin i++; continue; end
      i++;
      n = int'(stream[i]); i++;
      if (n == 0 || n > (1 << AW)) begin
        e.kind = 2; e.addr = 0; e.data = 0; expq.push_back(e);
        continue;
      end
      sum = 8'd0;
      for (int wi = 0; wi < n; wi++) begin
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
          w = w | (32'(stream[i]) << (8 * k));
          sum = sum + stream[i];
          i++;
        end
        e.kind = 0; e.addr = wi; e.data = w; expq.push_back(e);
      end
`ifdef LOADER_CHECKSUM_EN
      e.kind = (stream[i] == sum) ? 1 : 2; i++;
`else
      e.kind = 1;
`endif
      e.addr = 0; e.data = 0; expq.push_back(e);
    end
  endtask

  task automatic frame_begin(input int n);
    stream.push_back(8'hA5);
    stream.push_back(8'(n));
    fsum = 8'd0;
  endtask

  task automatic frame_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      stream.push_back(w[8*k +: 8]);
      fsum = fsum + w[8*k +: 8];
    end
  endtask

  task automatic frame_end(input bit bad);
`ifdef LOADER_CHECKSUM_EN
    stream.push_back(fsum ^ {7'd0, bad});
`else
    if (bad) fsum = 8'd0;
`endif
  endtask

  // Called right after a negedge; returns right after the accepting edge's negedge.
  task automatic send_byte(input logic [7:0] b);
    int gap;
    int g;
    gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    g = 0;
    while (!s_ready && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) lit("ready_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic drive_stream();
    int g;
    foreach (stream[i]) send_byte(stream[i]);
    s_valid = 1'b0;
    g = 0;
    while (expq.size() > 0 && g < 200) begin @(negedge clk); g++; end
    if (expq.size() > 0) begin
      lit("drain_timeout", 32'(expq.size()), 32'd0);
      expq.delete();
    end
    repeat (3) @(negedge clk);
    stream.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    lit({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    lit({tag, "_en"},      32'(load_mem_en), 32'd0);
    lit({tag, "_addr"},    32'(load_mem_addr), 32'd0);
    lit({tag, "_data"},    load_mem_data, 32'd0);
    lit({tag, "_busy"},    32'(busy), 32'd0);
    lit({tag, "_done"},    32'(done), 32'd0);
    lit({tag, "_err"},     32'(err), 32'd0);
  endtask

  // Single compare process: literal checks plus per-cycle checks against the model.
  always @(negedge clk) begin
    while (litq.size() > 0) begin
      lit_t t;
      t = litq.pop_front();
      chk(t.name, t.got, t.exp);
    end
    if (!rst_n) begin
      prev_en     <= 1'b0;
      prev_term   <= 1'b0;
      exp_done_nx <= 1'b0;
    end else begin
      if (exp_done_nx) chk("done_after_last_write", 32'(done), 32'd1);
      if (prev_en) begin
        chk("single_cycle_en", 32'(load_mem_en), 32'd0);
        chk("ready_after_write", 32'(s_ready | done), 32'd1);
      end
      if (prev_term) chk("busy_fall", 32'(busy), 32'd0);
      exp_done_nx <= 1'b0;
      if (load_mem_en) begin
        chk("ready_low_in_write", 32'(s_ready), 32'd0);
        chk("write_expected", 32'(expq.size() > 0 && expq[0].kind == 0), 32'd1);
        if (expq.size() > 0 && expq[0].kind == 0) begin
          ev_t e;
          e = expq.pop_front();
          chk("write_addr", 32'(load_mem_addr), 32'(e.addr));
          chk("write_data", load_mem_data, e.data);
`ifndef LOADER_CHECKSUM_EN
          exp_done_nx <= (expq.size() > 0 && expq[0].kind == 1);
`endif
        end
        mem[load_mem_addr] = load_mem_data;
      end
      if (done || err) begin
        chk("busy_at_term", 32'(busy), 32'd1);
        chk("done_err_exclusive", 32'(done & err), 32'd0);
        chk("term_expected", 32'(expq.size() > 0 && expq[0].kind != 0), 32'd1);
        if (expq.size() > 0 && expq[0].kind != 0) begin
          ev_t e;
          e = expq.pop_front();
          chk("term_kind", done ? 32'd1 : 32'd2, 32'(e.kind));
        end
      end
      prev_en   <= load_mem_en;
      prev_term <= done | err;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    foreach (mem[i]) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word frame
    frame_begin(2); frame_word(32'h12345678); frame_word(32'hDEADBEEF); frame_end(1'b0);
    model_frames();
    lit("model_pin_w1", expq[1].data, 32'hDEADBEEF);
    drive_stream();
    lit("mem0_frameA", mem[0], 32'h12345678);
    lit("mem1_frameA", mem[1], 32'hDEADBEEF);
    lit("busy_idle_A", 32'(busy), 32'd0);

    // Leading garbage ignored
    stream.push_back(8'h00); stream.push_back(8'hFF);
    frame_begin(1); stream.push_back(8'h04); stream.push_back(8'h03);
    stream.push_back(8'h02); stream.push_back(8'h01);
    fsum = 8'h0A; frame_end(1'b0);
    model_frames();
    drive_stream();
    lit("mem0_garbage", mem[0], 32'h01020304);

    // Bad lengths: 0 and 2^AW+1
    frame_begin(0); frame_begin(17);
    model_frames();
    lit("model_pin_badlen", 32'(expq.size()), 32'd2);
    drive_stream();
    lit("mem0_after_badlen", mem[0], 32'h01020304);

    // Full-memory frame
    frame_begin(16);
    for (int i = 0; i < 16; i++) begin words[i] = $urandom; frame_word(words[i]); end
    frame_end(1'b0);
    model_frames();
    drive_stream();
    lit("mem15_full", mem[15], words[15]);
    lit("mem0_full_nowrap", mem[0], words[0]);

    // Randomized frames with garbage, bad lengths and (optionally) bad checksums
    for (int f = 0; f < 10; f++) begin
      int n;
      int ng;
      ng = int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        stream.push_back((r == 8'hA5) ? 8'h5A : r);
      end
      if ($urandom_range(0, 7) == 0) begin
        frame_begin(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255)));
      end else begin
        n = int'($urandom_range(1, 16));
        frame_begin(n);
        for (int i = 0; i < n; i++) frame_word($urandom);
        frame_end($urandom_range(0, 3) == 0);
      end
      model_frames();
      drive_stream();
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum good (0A) then bad (0B)
    frame_begin(1); frame_word(32'h04030201); stream.push_back(8'h0A);
    frame_begin(1); frame_word(32'h04030201); stream.push_back(8'h0B);
    model_frames();
    lit("model_pin_csum_ok", 32'(expq[1].kind), 32'd1);
    lit("model_pin_csum_bad", 32'(expq[3].kind), 32'd2);
    drive_stream();
    lit("mem0_csum", mem[0], 32'h04030201);
`endif

    // Reset mid-frame after two data bytes
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    s_valid = 1'b0;
    @(negedge clk);
    lit("busy_mid_frame", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    words[0] = $urandom;
    frame_begin(1); frame_word(words[0]); frame_end(1'b0);
    model_frames();
    drive_stream();
    lit("mem0_after_reset", mem[0], words[0]);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
